mem_ctrl_ram: RTL



---
 rtl/mem_ctrl_ram.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram: single-port synchronous RAM with a valid/ready request port
// and a fixed-latency, valid-qualified read response channel.
//
// After reset an init sweep writes INIT_VAL to every location, one per cycle,
// while busy=1 and req_ready=0. Once the sweep finishes the block stays in RUN
// and accepts one read or write per cycle until the next reset.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1. A request presented while req_ready=0 is ignored; the requester
// holds it until it sees ready. Responses have no backpressure: every accepted
// read produces exactly one rsp_valid pulse two edges after the accept edge.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  block accepts a request this cycle
//   req_wr     1 = write, 0 = read
//   req_addr   request address (ADDR_W bits)
//   req_wdata  write data (DATA_W bits)
//   rsp_valid  read data valid (one-cycle pulse per read)
//   rsp_rdata  read data; holds its last value while rsp_valid=0
//   busy       init sweep in progress
module mem_ctrl_ram #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read pipeline: stage 1 holds the captured address, stage 2 the array
    // data, and the response registers present it one edge later.
    logic              rd_v1;
    logic              rd_v2;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;

    logic accept;
    logic wr_accept;
    logic rd_accept;

    assign accept    = req_valid & req_ready;
    assign wr_accept = accept & req_wr;
    assign rd_accept = accept & ~req_wr;

    // Control FSM, read-valid pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    // The last location is written this edge; ready rises
                    // together with the state change so it is seen next cycle.
                    if (&init_cnt) begin
                        state     <= ST_RUN;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase

            rd_v1     <= rd_accept;
            rd_v2     <= rd_v1;
            rsp_valid <= rd_v2;
            if (rd_v2) begin
                rsp_rdata <= rd_data_q;
            end
        end
    end

    // Storage and read datapath. The array is never cleared by reset itself;
    // only the sweep that follows reset rewrites it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= INIT_VAL;
            end else if (wr_accept) begin
                mem[req_addr] <= req_wdata;
            end
        end
        if (rd_accept) begin
            rd_addr_q <= req_addr;
        end
        // The array is read one edge after the accept, so a write accepted
        // on the previous edge is already visible to a following read.
        if (rd_v1) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

endmodule
